// File: rtl/rf_alu_pipe_if.sv
// Handshake/bus bundle for rf_alu_pipe: issue side (in_*, instr, controls) and result side (out_*).
// Latency: none, wires only.
// Backpressure: in_ready is driven by the pipe; out_ready is driven by the consumer.
//
// Port summary:
//   issue  : in_valid, in_ready, instr[31:0], alu_ctrl[3:0], reg_write, reg_set, set_data[XLEN-1:0]
//   result : out_valid, out_ready, rd1, rd2, alu_result [XLEN-1:0], zero, out_rd[4:0]
interface rf_alu_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [3:0]      alu_ctrl;
    logic            reg_write;
    logic            reg_set;
    logic [XLEN-1:0] set_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [4:0]      out_rd;

    // Producer/consumer side (testbench or upstream logic).
    modport master (
        output in_valid, instr, alu_ctrl, reg_write, reg_set, set_data, out_ready,
        input  in_ready, out_valid, rd1, rd2, alu_result, zero, out_rd
    );

    // Pipe side.
    modport slave (
        input  in_valid, instr, alu_ctrl, reg_write, reg_set, set_data, out_ready,
        output in_ready, out_valid, rd1, rd2, alu_result, zero, out_rd
    );
endinterface

// File: rtl/rf_alu_pipe.sv
// Register file + ALU in a two-stage pipe (S1 latched operands, S2 registered outputs).
// Latency: an op offered in cycle N shows on out_valid in cycle N+2; one op per cycle sustained.
// Backpressure: S2 holds while out_ready=0; S1 stalls behind it, and in_ready drops when S1 cannot drain.
//
// Port summary:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset; clears both stages, the register file and the outputs
//   bus   : rf_alu_pipe_if.slave (see rf_alu_pipe_if.sv)
module rf_alu_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_alu_pipe_if.slave  bus
);
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);

    // ---------------- state ----------------
    logic            r_s1_vld;
    logic [XLEN-1:0] r_s1_a;
    logic [XLEN-1:0] r_s1_b;
    logic [3:0]      r_s1_ctrl;
    logic [4:0]      r_s1_rd;
    logic            r_s1_we;
    logic            r_s1_set_en;
    logic [XLEN-1:0] r_s1_set_dat;

    logic            r_s2_vld;
    logic [XLEN-1:0] r_s2_a;
    logic [XLEN-1:0] r_s2_b;
    logic [XLEN-1:0] r_s2_res;
    logic            r_s2_zero;
    logic [4:0]      r_s2_rd;

    logic [XLEN-1:0] r_regs [NREG];

    // ---------------- handshake ----------------
    logic w_adv;
    logic w_accept;

    assign w_adv        = r_s1_vld && (!r_s2_vld || bus.out_ready);
    assign bus.in_ready = !r_s1_vld || w_adv;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // ---------------- S1 ALU ----------------
    logic [SW-1:0]   w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_s1_res;
    logic            w_lt_s;
    logic            w_lt_u;

    assign w_shamt = r_s1_b[SW-1:0];
    assign w_lt_s  = $signed(r_s1_a) < $signed(r_s1_b);
    assign w_lt_u  = r_s1_a < r_s1_b;

    always_comb begin
        w_alu = '0;
        unique case (r_s1_ctrl)
            4'b0000: w_alu = r_s1_a & r_s1_b;
            4'b0001: w_alu = r_s1_a | r_s1_b;
            4'b0010: w_alu = r_s1_a + r_s1_b;
            4'b0110: w_alu = r_s1_a - r_s1_b;
            4'b0011: w_alu = r_s1_a ^ r_s1_b;
            4'b0100: w_alu = r_s1_a << w_shamt;
            4'b0101: w_alu = r_s1_a >> w_shamt;
            4'b0111: w_alu = XLEN'($signed(r_s1_a) >>> w_shamt);
            4'b1000: w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
            4'b1001: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
            default: w_alu = '0;
        endcase
    end

    assign w_s1_res = r_s1_set_en ? r_s1_set_dat : w_alu;

    // ---------------- register file write / forwarding ----------------
    logic [RW-1:0] w_s1_rd_idx;
    logic          w_s1_wr;

    assign w_s1_rd_idx = r_s1_rd[RW-1:0];
    // The write lands on the same edge that S1 moves to S2; x0 is never written.
    assign w_s1_wr     = w_adv && (r_s1_we || r_s1_set_en) && (w_s1_rd_idx != '0);

    logic [RW-1:0]   w_rs1_idx;
    logic [RW-1:0]   w_rs2_idx;
    logic [XLEN-1:0] w_rs1_rf;
    logic [XLEN-1:0] w_rs2_rf;
    logic [XLEN-1:0] w_rs1_dat;
    logic [XLEN-1:0] w_rs2_dat;

    assign w_rs1_idx = bus.instr[15 +: RW];
    assign w_rs2_idx = bus.instr[20 +: RW];
    assign w_rs1_rf  = (w_rs1_idx == '0) ? '0 : r_regs[w_rs1_idx];
    assign w_rs2_rf  = (w_rs2_idx == '0) ? '0 : r_regs[w_rs2_idx];

    // A new op can only be accepted with S1 occupied when S1 is leaving, so the
    // S1 result is exactly the value the register file will hold after this edge.
    // w_s1_wr already excludes x0, which keeps x0 reading as zero.
    assign w_rs1_dat = (w_s1_wr && (w_rs1_idx == w_s1_rd_idx)) ? w_s1_res : w_rs1_rf;
    assign w_rs2_dat = (w_s1_wr && (w_rs2_idx == w_s1_rd_idx)) ? w_s1_res : w_rs2_rf;

    // Fields of instr outside rs1/rs2/rd carry no meaning here.
    logic w_unused_instr;
    assign w_unused_instr = ^bus.instr;

    // ---------------- sequential ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_ctrl    <= '0;
            r_s1_rd      <= '0;
            r_s1_we      <= 1'b0;
            r_s1_set_en  <= 1'b0;
            r_s1_set_dat <= '0;
        end else begin
            if (w_accept) begin
                r_s1_vld     <= 1'b1;
                r_s1_a       <= w_rs1_dat;
                r_s1_b       <= w_rs2_dat;
                r_s1_ctrl    <= bus.alu_ctrl;
                r_s1_rd      <= bus.instr[11:7];
                r_s1_we      <= bus.reg_write;
                r_s1_set_en  <= bus.reg_set;
                r_s1_set_dat <= bus.set_data;
            end else if (w_adv) begin
                r_s1_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_a    <= '0;
            r_s2_b    <= '0;
            r_s2_res  <= '0;
            r_s2_zero <= 1'b0;
            r_s2_rd   <= '0;
        end else begin
            if (w_adv) begin
                r_s2_vld  <= 1'b1;
                r_s2_a    <= r_s1_a;
                r_s2_b    <= r_s1_b;
                r_s2_res  <= w_s1_res;
                r_s2_zero <= (r_s1_a == r_s1_b);
                r_s2_rd   <= r_s1_rd;
            end else if (r_s2_vld && bus.out_ready) begin
                r_s2_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_s1_wr) begin
            r_regs[w_s1_rd_idx] <= w_s1_res;
        end
    end

    // ---------------- outputs ----------------
    assign bus.out_valid  = r_s2_vld;
    assign bus.rd1        = r_s2_a;
    assign bus.rd2        = r_s2_b;
    assign bus.alu_result = r_s2_res;
    assign bus.zero       = r_s2_zero;
    assign bus.out_rd     = r_s2_rd;
endmodule

// File: doc/rf_alu_pipe.md
RF_ALU_PIPE -- requirements
Module: rf_alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath and register width (legal: 32, 64).
REQ-002 Parameter NREG, default 32, SHALL set register count (legal: 16, 32); register index = low log2(NREG) bits of each instr field.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  operation offered; in_ready  out  1  operation accepted when in_valid and in_ready are both 1.
REQ-006 instr  in  32  rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
REQ-007 alu_ctrl  in  4  operation code; reg_write  in  1  write result to rd; reg_set  in  1  write set_data to rd instead of the ALU result.
REQ-008 set_data  in  XLEN  register preload value.
REQ-009 out_valid  out  1  result held; out_ready  in  1  result consumed when out_valid and out_ready are both 1.
REQ-010 rd1, rd2, alu_result  out  XLEN  operands and result of the held operation; zero  out  1  operands equal; out_rd  out  5  destination of the held operation.

Function
REQ-011 The pipeline SHALL have two stages: S1 (latched operands) and S2 (registered outputs), each with its own valid bit.
REQ-012 On acceptance, the block SHALL read rs1/rs2 and latch operands, alu_ctrl, rd, reg_write, reg_set and set_data into S1.
REQ-013 S1 SHALL advance into S2 when s1_valid is 1 and (s2_valid is 0 or out_ready is 1); in_ready SHALL equal (!s1_valid or S1 advances).
REQ-014 When S2 is consumed and S1 does not advance, s2_valid SHALL clear; when no operation is accepted and S1 advances, s1_valid SHALL clear.
REQ-015 Latency SHALL be 2 cycles from the acceptance edge to out_valid with no stall; sustained throughput SHALL be 1 operation per cycle while out_ready is 1.
REQ-016 ALU ops (a = rs1 value, b = rs2 value), evaluated in the S1 cycle:
- 0000 and; 0001 or; 0010 add; 0110 sub; 0011 xor
- 0100 sll; 0101 srl; 0111 sra (shift amount b[log2(XLEN)-1:0])
- 1000 slt (signed); 1001 sltu
- all other codes produce 0
REQ-017 Add/sub SHALL wrap modulo 2^XLEN; slt/sltu SHALL return 1 or 0 zero-extended.
REQ-018 zero SHALL be 1 when a == b, for every alu_ctrl.
REQ-019 S1 result SHALL be set_data if reg_set is 1, else the ALU output; it is registered to alu_result on the advance edge.
REQ-020 The register file SHALL be written on the S1 advance edge when reg_write or reg_set is 1 and rd != 0.
REQ-021 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-022 Forwarding: if an accepted operation reads register r != 0 while S1 is valid and advancing with a pending write to r, the S1 result SHALL be used instead of the register-file value.
REQ-023 S2 outputs SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-024 An operation with reg_write = 0 and reg_set = 0 SHALL still traverse the pipeline and produce outputs without writing a register.

Reset
REQ-025 While rst_n is 0, the block SHALL clear s1_valid and s2_valid, clear all registers to 0, drive rd1/rd2/alu_result/out_rd to 0 and zero to 0, and drive in_ready to 1 once rst_n is 1.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operations and perform no register write.

Verification
REQ-027 Preload x1 = 7 and x2 = 5, then add x3 = x1 + x2 -> out_valid at accept+2, alu_result = 12, zero = 0, x3 = 12.
REQ-028 Back-to-back add x3 = x1 + x2 followed by sub x4 = x3 - x1 -> second alu_result = 5 via forwarding.
REQ-029 Hold out_ready = 0 for 4 cycles with 3 operations offered -> in_ready drops after 2 are accepted, outputs are stable, then all 3 results appear in order.
REQ-030 sra with x1 = 0x80000000 and x2 = 4 (XLEN = 32) -> alu_result = 0xF8000000; slt of -1 vs 1 -> 1; sltu of -1 vs 1 -> 0.
REQ-031 Write to x0 with reg_set and set_data = 0xFFFF -> a later read of x0 gives rd1 = 0.
REQ-032 Assert rst_n = 0 with both stages valid -> out_valid = 0 and all registers 0; the pending write is not performed.
